// File: rtl/filter_out_decimator.sv
// Block-average decimator for the Q11.2 filter stream: sums 2^LOG2_DEC samples,
// rounds half-up to integer, clamps to the unsigned output range, and queues words in a 2-entry FIFO.
module filter_out_decimator #(
  parameter int NB_IN    = 13,
  parameter int NB_FRAC  = 2,
  parameter int NB_OUT   = 8,
  parameter int LOG2_DEC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_IN-1:0]  in_data,
  input  logic              in_valid,
  output logic [NB_OUT-1:0] out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  localparam int ACC_W = NB_IN + LOG2_DEC;
  localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
  localparam int RW    = ACC_W + 1;
  localparam int RND   = (NB_FRAC > 0) ? (1 << (NB_FRAC - 1)) : 0;
  localparam int EW    = NB_OUT + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'((1 << LOG2_DEC) - 1);
  localparam logic signed [RW-1:0] MAX_S    = RW'((1 << NB_OUT) - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [EW-1:0]           e0_q, e0_d, e1_q, e1_d;
  logic [1:0]              count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] in_ext, sum, avg;
  logic signed [RW-1:0]    r;
  logic [EW-1:0]           res;
  logic                    dump, pop;

  // Stream handshake: a word transfers on any rising edge where out_valid && out_ready;
  // out_valid/out_data depend only on flops, never on out_ready.
  always_comb begin
    in_ext = ACC_W'($signed(in_data));
    sum    = acc_q + in_ext;
    dump   = in_valid && (cnt_q == CNT_LAST);
    avg    = sum >>> LOG2_DEC;
    r      = (RW'(avg) + RW'(RND)) >>> NB_FRAC;
    if (r < 0) begin
      res = {1'b1, {NB_OUT{1'b0}}};
    end else if (r > MAX_S) begin
      res = {1'b1, {NB_OUT{1'b1}}};
    end else begin
      res = {1'b0, r[NB_OUT-1:0]};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (in_valid) begin
      if (dump) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum;
      end
    end
  end

  // Head always lives in e0; e1 only holds the second word when full.
  always_comb begin
    pop     = out_ready && (count_q != 2'd0);
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case ({pop, dump})
      2'b11: begin
        if (count_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = res;
        end else begin
          e0_d = res;
        end
      end
      2'b10: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd0) begin
          e0_d    = res;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          e1_d    = res;
          count_d = 2'd2;
        end else begin
          ovf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? e0_q[NB_OUT-1:0] : '0;
  assign out_sat   = out_valid ? e0_q[NB_OUT] : 1'b0;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_filter_out_decimator.sv
// Bench for filter_out_decimator: scenario tasks drive blocks and push expected {sat,data}
// words; a negedge monitor pops and compares every word the consumer accepts.
module tb_filter_out_decimator;

  logic        clk;
  logic        rst;
  logic [12:0] in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  logic [8:0] exp_q[$];
  int total;
  int bad;

  filter_out_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard monitor: a word accepted at the coming edge must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got sat=%0b data=%0d, required no word", out_sat, out_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({out_sat, out_data} !== e) begin
          bad++;
          $display("FAIL stream_word: got sat=%0b data=%0d, required sat=%0b data=%0d",
                   out_sat, out_data, e[8], e[7:0]);
        end
      end
    end
    if (!out_valid) begin
      total++;
      if (out_data !== 8'd0 || out_sat !== 1'b0) begin
        bad++;
        $display("FAIL idle_zero: got sat=%0b data=%0d, required 0/0", out_sat, out_data);
      end
    end
  end

  function automatic logic [8:0] model(input int s0, input int s1, input int s2, input int s3);
    int sum, avg, r;
    sum = s0 + s1 + s2 + s3;
    avg = sum >>> 2;
    r   = (avg + 2) >>> 2;
    if (r < 0) return {1'b1, 8'd0};
    if (r > 255) return {1'b1, 8'hFF};
    return {1'b0, r[7:0]};
  endfunction

  // driver tasks: all input changes happen 1 time unit after a rising edge
  task automatic send(input int v);
    in_data  = v[12:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send4(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b d=%0d s=%0b o=%0b, required all 0",
               out_valid, out_data, out_sat, ovf);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'd100});
    send4(400);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd100) begin
      bad++;
      $display("FAIL basic_latency: got v=%0b d=%0d, required v=1 d=100", out_valid, out_data);
    end
    exp_q.push_back({1'b0, 8'd100});
    send(401); send(401); send(402); send(402);
    exp_q.push_back({1'b0, 8'd101});
    send4(402);
    idle(3);
  endtask

  task automatic test_sat();
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 8'd0});
    send4(-40);
    exp_q.push_back({1'b1, 8'd255});
    send4(1100);
    exp_q.push_back({1'b0, 8'd255});
    send4(1020);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd255 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_edge: got d=%0d s=%0b, required d=255 s=0", out_data, out_sat);
    end
    idle(3);
  endtask

  task automatic test_gapped();
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'd100});
    for (int i = 0; i < 3; i++) begin
      send(400);
      idle(3);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL gapped_early: got out_valid=%0b after sample %0d, required 0", out_valid, i);
      end
    end
    send(400);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd100) begin
      bad++;
      $display("FAIL gapped_word: got v=%0b d=%0d, required v=1 d=100", out_valid, out_data);
    end
    idle(3);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'd10});
    exp_q.push_back({1'b0, 8'd20});
    send4(40);
    send4(80);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_early: got ovf=%0b, required 0", ovf);
    end
    send4(120);
    total++;
    if (ovf !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'd10) begin
      bad++;
      $display("FAIL ovf_set: got ovf=%0b v=%0b d=%0d, required ovf=1 v=1 d=10", ovf, out_valid, out_data);
    end
    out_ready = 1'b1;
    idle(1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd20) begin
      bad++;
      $display("FAIL ovf_drain: got v=%0b d=%0d, required v=1 d=20", out_valid, out_data);
    end
    idle(1);
    total++;
    if (out_valid !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got v=%0b ovf=%0b, required v=0 ovf=1", out_valid, ovf);
    end
    idle(2);
  endtask

  task automatic test_full_pop_push();
    pulse_reset();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'd10});
    exp_q.push_back({1'b0, 8'd20});
    exp_q.push_back({1'b0, 8'd30});
    send4(40);
    send4(80);
    for (int i = 0; i < 3; i++) send(120);
    in_data   = 13'd120;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (ovf !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd20) begin
      bad++;
      $display("FAIL full_pop_push: got ovf=%0b v=%0b d=%0d, required ovf=0 v=1 d=20", ovf, out_valid, out_data);
    end
    out_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send4(40);
    send(800);
    send(800);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got v=%0b d=%0d s=%0b o=%0b, required all 0", out_valid, out_data, out_sat, ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'd100});
    send4(400);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd100) begin
      bad++;
      $display("FAIL reset_residue: got v=%0b d=%0d, required v=1 d=100", out_valid, out_data);
    end
    idle(3);
  endtask

  task automatic test_random();
    int s[4];
    out_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(0, 1500)) - 200;
      exp_q.push_back(model(s[0], s[1], s[2], s[3]));
      for (int i = 0; i < 4; i++) begin
        send(s[i]);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end
    end
    idle(3);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_sat();
    test_gapped();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_words: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
